// File: rtl/prt_tx_streamer_if.sv
// Handshake bundle between prt_tx_streamer (master) and its environment (slave):
// the tag queue, the PRT read port, the TX stream and the slot-return/status strobes.
interface prt_tx_streamer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int TAG_WIDTH  = 8,
  parameter int LEN_WIDTH  = 11
);
  logic                  tag_valid;
  logic [TAG_WIDTH-1:0]  tag_data;
  logic [LEN_WIDTH-1:0]  tag_len;
  logic                  tag_drop;
  logic                  tag_ready;
  logic                  prt_read_en;
  logic [ADDR_WIDTH-1:0] prt_read_addr;
  logic [DATA_WIDTH-1:0] prt_data_out;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_last;
  logic                  tx_ready;
  logic                  tx_done;
  logic                  slot_free_valid;
  logic [TAG_WIDTH-1:0]  slot_free_tag;
  logic                  len_err;
  logic                  busy;

  modport master (
    input  tag_valid, tag_data, tag_len, tag_drop, prt_data_out, tx_ready,
    output tag_ready, prt_read_en, prt_read_addr, tx_data, tx_valid, tx_last,
           tx_done, slot_free_valid, slot_free_tag, len_err, busy
  );

  modport slave (
    output tag_valid, tag_data, tag_len, tag_drop, prt_data_out, tx_ready,
    input  tag_ready, prt_read_en, prt_read_addr, tx_data, tx_valid, tx_last,
           tx_done, slot_free_valid, slot_free_tag, len_err, busy
  );
endinterface

// File: rtl/prt_tx_streamer.sv
// Egress streamer: pops verdict tags, reads frame bytes from the PRT through a 2-entry skid
// buffer onto the TX stream, then frees the slot. Define TX_STATS_EN to add saturating counters.
module prt_tx_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int TAG_WIDTH  = 8,
  parameter int LEN_WIDTH  = 11,
  parameter int MAX_LEN    = 1518
) (
  input  logic        clk,
  input  logic        reset,
`ifdef TX_STATS_EN
  output logic [31:0] stat_frames_tx_o,
  output logic [31:0] stat_bytes_tx_o,
  output logic [31:0] stat_frames_drop_o,
`endif
  prt_tx_streamer_if.master bus
);

  localparam logic [LEN_WIDTH-1:0] MAX_LEN_L = LEN_WIDTH'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISCARD,
    S_STREAM,
    S_DRAIN,
    S_FREE
  } state_t;

  state_t                state_q, state_d;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic                  err_q;
  logic [LEN_WIDTH-1:0]  rd_cnt_q;
  logic [LEN_WIDTH-1:0]  out_cnt_q;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] skid_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            occ_q, occ_d;
  logic                  tx_done_q;

  logic                  pop_tag, len_bad, rd_issue;
  logic                  tx_valid_w, tx_last_w, accept, push, pop_skid;
  logic [DATA_WIDTH-1:0] head;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign pop_tag  = (state_q == S_IDLE) && reset && bus.tag_valid;
  assign len_bad  = (bus.tag_len == '0) || (bus.tag_len > MAX_LEN_L);
  // Skid occupancy plus the outstanding read must stay below 2 so no returning word is lost.
  assign rd_issue = (state_q == S_STREAM) && ((occ_q == 2'd0) || ((occ_q == 2'd1) && !inflight_q));
  assign rd_addr  = ADDR_WIDTH'(tag_q) + ADDR_WIDTH'(rd_cnt_q);

  // Returning PRT data bypasses the skid when it is empty; older buffered words go first.
  assign tx_valid_w = (occ_q != 2'd0) || inflight_q;
  assign head       = (occ_q != 2'd0) ? skid_q[rd_ptr_q] : bus.prt_data_out;
  assign tx_last_w  = tx_valid_w && (out_cnt_q == len_q - 1'b1);
  assign accept     = tx_valid_w && bus.tx_ready;
  assign push       = inflight_q && !((occ_q == 2'd0) && accept);
  assign pop_skid   = accept && (occ_q != 2'd0);

  always_comb begin
    occ_d = occ_q;
    unique case ({push, pop_skid})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (pop_tag) state_d = (bus.tag_drop || len_bad) ? S_DISCARD : S_STREAM;
      S_DISCARD: state_d = S_FREE;
      S_STREAM:  if (rd_issue && (rd_cnt_q == len_q - 1'b1)) state_d = S_DRAIN;
      S_DRAIN:   if (accept && tx_last_w) state_d = S_FREE;
      S_FREE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      tag_q      <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
      rd_cnt_q   <= '0;
      out_cnt_q  <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_issue;
      occ_q      <= occ_d;
      tx_done_q  <= accept && tx_last_w;
      if (pop_tag) begin
        tag_q     <= bus.tag_data;
        len_q     <= bus.tag_len;
        err_q     <= len_bad;
        rd_cnt_q  <= '0;
        out_cnt_q <= '0;
      end else begin
        if (rd_issue) rd_cnt_q <= rd_cnt_q + 1'b1;
        if (accept)   out_cnt_q <= out_cnt_q + 1'b1;
      end
      if (push)     wr_ptr_q <= ~wr_ptr_q;
      if (pop_skid) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) skid_q[wr_ptr_q] <= bus.prt_data_out;
  end

  assign bus.tag_ready       = (state_q == S_IDLE) && reset;
  assign bus.prt_read_en     = rd_issue;
  assign bus.prt_read_addr   = rd_issue ? rd_addr : '0;
  assign bus.tx_valid        = tx_valid_w;
  assign bus.tx_data         = tx_valid_w ? head : '0;
  assign bus.tx_last         = tx_last_w;
  assign bus.tx_done         = tx_done_q;
  assign bus.slot_free_valid = (state_q == S_FREE);
  assign bus.slot_free_tag   = (state_q == S_FREE) ? tag_q : '0;
  assign bus.len_err         = (state_q == S_DISCARD) && err_q;
  assign bus.busy            = (state_q != S_IDLE);

`ifdef TX_STATS_EN
  logic [31:0] frames_tx_q, bytes_tx_q, frames_drop_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      frames_tx_q   <= '0;
      bytes_tx_q    <= '0;
      frames_drop_q <= '0;
    end else begin
      if (accept && tx_last_w && (frames_tx_q != '1)) frames_tx_q <= frames_tx_q + 1'b1;
      if (accept && (bytes_tx_q != '1))               bytes_tx_q  <= bytes_tx_q + 1'b1;
      if ((state_q == S_DISCARD) && (frames_drop_q != '1)) frames_drop_q <= frames_drop_q + 1'b1;
    end
  end

  assign stat_frames_tx_o   = frames_tx_q;
  assign stat_bytes_tx_o    = bytes_tx_q;
  assign stat_frames_drop_o = frames_drop_q;
`endif

endmodule
